// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers and shared types for the AES InvMixColumns engine.
// Constant multiplies are xtime chains only; no general multipliers.
package aes_gf_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Rows of the InvMixColumns matrix; INV_COEF[r][k] multiplies input row k for output row r.
    localparam logic [7:0] INV_COEF [4][4] = '{
        '{8'h0e, 8'h0b, 8'h0d, 8'h09},
        '{8'h09, 8'h0e, 8'h0b, 8'h0d},
        '{8'h0d, 8'h09, 8'h0e, 8'h0b},
        '{8'h0b, 8'h0d, 8'h09, 8'h0e}
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul_const(input logic [7:0] b, input logic [7:0] coef);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] res;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        unique case (coef)
            8'h09:   res = x8 ^ b;
            8'h0b:   res = x8 ^ x2 ^ b;
            8'h0d:   res = x8 ^ x4 ^ b;
            8'h0e:   res = x8 ^ x4 ^ x2;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

    // Column c of a row-major state as {row0, row1, row2, row3}.
    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
        logic [31:0] col;
        col = '0;
        for (int r = 0; r < 4; r++) begin
            col[31-8*r -: 8] = s[127-8*(4*r+int'(c)) -: 8];
        end
        return col;
    endfunction

    function automatic logic [127:0] put_col(input logic [127:0] s, input logic [1:0] c,
                                             input logic [31:0] col);
        logic [127:0] res;
        res = s;
        for (int r = 0; r < 4; r++) begin
            res[127-8*(4*r+int'(c)) -: 8] = col[31-8*r -: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_inv_mix_columns_seq_if.sv
// Input/output valid-ready bundle for the InvMixColumns engine.
interface aes_inv_mix_columns_seq_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/aes_inv_mix_col.sv
// Combinational InvMixColumns on one 32-bit column {row0, row1, row2, row3}.
module aes_inv_mix_col
    import aes_gf_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] b [4];

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            b[r] = col_i[31-8*r -: 8];
        end
        col_o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                col_o[31-8*r -: 8] = col_o[31-8*r -: 8] ^ gmul_const(b[k], INV_COEF[r][k]);
            end
        end
    end

endmodule

// File: rtl/aes_inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: latches one state, transforms COLS_PER_CYCLE columns per
// clock into a result buffer, then holds it on a valid/ready output.
module aes_inv_mix_columns_seq
    import aes_gf_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input logic                     clk,
    input logic                     rst,
    aes_inv_mix_columns_seq_if.slave bus
);

    // The edge that starts at this count writes column 3.
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

    state_t       state_q, state_d;
    logic [1:0]   col_cnt_q, col_cnt_d;
    logic [127:0] src_q, src_d;
    logic [127:0] res_q, res_d;
    logic         in_ready_c;
    logic         out_valid_c;

    logic [1:0]   col_idx [COLS_PER_CYCLE];
    logic [31:0]  col_in  [COLS_PER_CYCLE];
    logic [31:0]  col_out [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : gen_col
        assign col_idx[g] = col_cnt_q + 2'(g);
        assign col_in[g]  = get_col(src_q, col_idx[g]);

        aes_inv_mix_col u_col (
            .col_i (col_in[g]),
            .col_o (col_out[g])
        );
    end

    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        src_d       = src_q;
        res_d       = res_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    src_d     = bus.in_data;
                    col_cnt_d = 2'd0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
                    res_d = put_col(res_d, col_idx[g], col_out[g]);
                end
                col_cnt_d = col_cnt_q + CNT_STEP;
                if (col_cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                in_ready_c  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        src_d     = bus.in_data;
                        col_cnt_d = 2'd0;
                        state_d   = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            col_cnt_q <= 2'd0;
            src_q     <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            src_q     <= src_d;
            res_q     <= res_d;
        end
    end

    // State sits in IDLE during reset, so in_ready must be masked explicitly.
    assign bus.in_ready  = in_ready_c & ~rst;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = res_q;

endmodule

// File: doc/aes_inv_mix_columns_seq.md
Name: aes_inv_mix_columns_seq

Overview:
- Sequential AES InvMixColumns engine for the decrypt/verify path, the inverse of the combinational forward MixColumns block.
- Takes a 128-bit state matrix, packed row-major. Byte (row r, col c) sits at bits [127-8*(4r+c) -: 8], the same packing as the forward block, so forward followed by this block is the identity.
- Processes COLS_PER_CYCLE columns per clock and buffers one result block.
- Valid/ready handshake on both the input and output sides.

Parameters:
- COLS_PER_CYCLE, default 1: number of columns transformed per cycle. Legal values are 1, 2, 4. Compute phase lasts NCYC = 4/COLS_PER_CYCLE cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds a valid state.
- in_ready  out  1  block can accept a state this cycle.
- in_data  in  128  input state matrix, row-major packed.
- out_valid  out  1  out_data holds a finished result.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  128  InvMixColumns result, row-major packed.

Behaviour:
- Transform: out column c = M x in column c over GF(2^8), reduction polynomial 0x11B.
  - M rows are [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e].
  - Multiplies are built from xtime chains: x2 = xtime, x4, x8; 09 = x8^x1; 0b = x8^x2^x1; 0d = x8^x4^x1; 0e = x8^x4^x2.
  - No true multipliers; all arithmetic is 8-bit and truncating.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. If in_valid, latch in_data into src_reg, clear col_cnt, go to CALC.
  - CALC: in_ready=0, in_data ignored. Each edge computes columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 from src_reg, writes them into res_reg, and adds COLS_PER_CYCLE to col_cnt. The edge that writes column 3 moves to DONE.
  - DONE: out_valid=1 and out_data=res_reg, both held stable while out_ready=0.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=1 and in_valid=1: in_ready=1, the new block is latched on the same edge, go to CALC (back-to-back).
    - in_ready in DONE equals out_ready (combinational).
- Latency: out_valid rises NCYC edges after the input-accept edge; NCYC=4 for the default.
  - Throughput is one block per NCYC+1 cycles.
- Output updates:
  - out_data is driven from res_reg at all times, and res_reg changes only in CALC. Consumers qualify out_data with out_valid.
  - Reset values: out_valid=0, out_data=0, in_ready=0 while rst is asserted, state=IDLE, col_cnt=0, src_reg=0, res_reg=0.
- Reset mid-CALC or mid-DONE: the block is dropped immediately (asynchronous). No partial result is ever presented. The first cycle after reset release has in_ready=1.
- No overflow or underflow is possible, and there is no internal FIFO.
- col_cnt is 2 bits and wraps only at the DONE transition.

Decomposition:
- Package aes_gf_pkg holds:
  - AES_POLY=8'h1B;
  - function xtime(8b) and function gmul_const(byte, coef) for coef in {09, 0b, 0d, 0e};
  - typedef state_t enum {IDLE, CALC, DONE};
  - the 4x4 inverse coefficient constant.
- Sub-module aes_inv_mix_col (combinational): 32-bit column in, 32-bit column out. Instantiated COLS_PER_CYCLE times and fed by a column mux on col_cnt.

Test Plan:
- Uniform columns: in_data=128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc, out_ready=1 -> out_valid 4 cycles after accept, out_data=128'hdbdbdbdb_13131313_53535353_45454545.
- Mixed columns (col0=8e4da1bc, col1=9fdc589d, col2=c6c6c6c6, col3=4d7ebdf8): in_data=128'h8e9fc64d_4ddcc67e_a158c6bd_bc9dc6f8 -> out_data=128'hdbf2c62d_130ac626_5322c631_455cc64c. Repeat with COLS_PER_CYCLE=2 and 4 to get latencies 2 and 1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data and out_valid stable and in_ready=0. Then out_ready=1 with in_valid=1 -> new block accepted the same cycle, out_valid falls next cycle, second result arrives 4 cycles later.
- Reset mid-CALC: assert rst 2 cycles after accept -> out_valid=0 and out_data=0 immediately. After release, in_ready=1 and the next block processes correctly.
- Round trip: 1000 random states through the team's forward MixColumns model, then this block -> output equals the original state. in_valid gaps are random and out_ready is random.
- Fixed points: in_data=all 8'h01 and all 8'hc6 -> out_data equals in_data.
